// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap/MRET sequencer: machine-mode CSR
// addresses, mstatus bit positions and the sequencer state encoding.
// Contents: CSR_* addresses, MSTATUS_* bit indices, seq_state_e.
package csr_pkg;

   // Machine-mode CSR addresses touched by the trap/MRET sequences
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // mstatus fields
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      T_EPC    = 3'd1,
      T_CAUSE  = 3'd2,
      T_TVAL   = 3'd3,
      T_STATUS = 3'd4,
      T_REDIR  = 3'd5,
      M_STATUS = 3'd6,
      M_REDIR  = 3'd7
   } seq_state_e;

endpackage : csr_pkg

// File: rtl/csr_trap_sequencer.sv
// Purpose : sequences trap entry (mepc/mcause/mtval/mstatus writes, mtvec
//           redirect) and MRET (mstatus update, mepc redirect) over a single
//           CSR write port, arbitrating against instruction CSR writes.
// Latency : trap 6 cycles accept->redirect, MRET 3 cycles; instruction
//           writes pass through combinationally in IDLE.
// Backpressure: inst_csr_ready low (write held off) and stall high while a
//           sequence is running or a trap/MRET request is present.
// Ports   : clk/reset; trap_* and mret_req from the pipeline; inst_csr_* write
//           request; csr_we/waddr/wdata write port and csr_raddr/rdata
//           combinational read port to the CSR file; stall and redirect_*
//           towards the pipeline front end.
module csr_trap_sequencer
   import csr_pkg::*;
#(
   parameter int REG_WIDTH = 64,
   parameter int CSR       = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 trap_req,
   input  logic [REG_WIDTH-1:0] trap_pc,
   input  logic [REG_WIDTH-1:0] trap_cause,
   input  logic [REG_WIDTH-1:0] trap_tval,
   input  logic                 mret_req,
   input  logic                 inst_csr_valid,
   input  logic [CSR-1:0]       inst_csr_addr,
   input  logic [REG_WIDTH-1:0] inst_csr_wdata,
   output logic                 inst_csr_ready,
   output logic                 csr_we,
   output logic [CSR-1:0]       csr_waddr,
   output logic [REG_WIDTH-1:0] csr_wdata,
   output logic [CSR-1:0]       csr_raddr,
   input  logic [REG_WIDTH-1:0] csr_rdata,
   output logic                 stall,
   output logic                 redirect_valid,
   output logic [REG_WIDTH-1:0] redirect_pc
);

   localparam logic [REG_WIDTH-1:0] ALIGN_MASK = ~REG_WIDTH'(3);

   seq_state_e           state_q, state_d;
   logic [REG_WIDTH-1:0] pc_q, pc_d;
   logic [REG_WIDTH-1:0] cause_q, cause_d;
   logic [REG_WIDTH-1:0] tval_q, tval_d;

   logic                 we_raw;
   logic                 redir_raw;
   logic [REG_WIDTH-1:0] status_trap;
   logic [REG_WIDTH-1:0] status_mret;

   // mstatus rewrite for trap entry and for MRET, both derived from the
   // current mstatus value on the read port.
   always_comb begin
      status_trap                                = csr_rdata;
      status_trap[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
      status_trap[MSTATUS_MIE]                   = 1'b0;
      status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      status_mret                                = csr_rdata;
      status_mret[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
      status_mret[MSTATUS_MPIE]                  = 1'b1;
      status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      cause_d        = cause_q;
      tval_d         = tval_q;
      we_raw         = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      csr_raddr      = '0;
      redir_raw      = 1'b0;
      redirect_pc    = '0;
      inst_csr_ready = 1'b0;

      unique case (state_q)
         IDLE: begin
            inst_csr_ready = ~trap_req & ~mret_req;
            if (trap_req) begin
               // mret_req in the same cycle is intentionally dropped
               pc_d    = trap_pc;
               cause_d = trap_cause;
               tval_d  = trap_tval;
               state_d = T_EPC;
            end else if (mret_req) begin
               state_d = M_STATUS;
            end else if (inst_csr_valid) begin
               we_raw    = 1'b1;
               csr_waddr = inst_csr_addr;
               csr_wdata = inst_csr_wdata;
            end
         end
         T_EPC: begin
            we_raw    = 1'b1;
            csr_waddr = CSR'(CSR_MEPC);
            csr_wdata = pc_q & ALIGN_MASK;
            state_d   = T_CAUSE;
         end
         T_CAUSE: begin
            we_raw    = 1'b1;
            csr_waddr = CSR'(CSR_MCAUSE);
            csr_wdata = cause_q;
            state_d   = T_TVAL;
         end
         T_TVAL: begin
            we_raw    = 1'b1;
            csr_waddr = CSR'(CSR_MTVAL);
            csr_wdata = tval_q;
            state_d   = T_STATUS;
         end
         T_STATUS: begin
            csr_raddr = CSR'(CSR_MSTATUS);
            we_raw    = 1'b1;
            csr_waddr = CSR'(CSR_MSTATUS);
            csr_wdata = status_trap;
            state_d   = T_REDIR;
         end
         T_REDIR: begin
            // direct mode only: the mtvec mode bits are discarded
            csr_raddr   = CSR'(CSR_MTVEC);
            redir_raw   = 1'b1;
            redirect_pc = csr_rdata & ALIGN_MASK;
            state_d     = IDLE;
         end
         M_STATUS: begin
            csr_raddr = CSR'(CSR_MSTATUS);
            we_raw    = 1'b1;
            csr_waddr = CSR'(CSR_MSTATUS);
            csr_wdata = status_mret;
            state_d   = M_REDIR;
         end
         M_REDIR: begin
            csr_raddr   = CSR'(CSR_MEPC);
            redir_raw   = 1'b1;
            redirect_pc = csr_rdata;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A reset arriving mid-sequence must not let the current step's write or
   // redirect escape in the reset cycle itself.
   assign csr_we         = we_raw & ~reset;
   assign redirect_valid = redir_raw & ~reset;
   assign stall          = (state_q != IDLE) | trap_req | mret_req;

endmodule : csr_trap_sequencer

// File: doc/csr_trap_sequencer.md
CSR_TRAP_SEQUENCER -- requirements
Module: csr_trap_sequencer

Interface
REQ-001 SHALL have parameters: REG_WIDTH, 64, CSR data width; CSR, 12, CSR address bits.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- reset  in  1  reset.
- trap_req  in  1  trap request from the pipeline.
- trap_pc  in  REG_WIDTH  PC of the faulting instruction.
- trap_cause  in  REG_WIDTH  mcause value.
- trap_tval  in  REG_WIDTH  mtval value.
- mret_req  in  1  MRET request.
- inst_csr_valid  in  1  write from a CSR instruction.
- inst_csr_addr  in  CSR  instruction write address.
- inst_csr_wdata  in  REG_WIDTH  final value to write (rw/rs/rc already resolved).
- inst_csr_ready  out  1  instruction write accepted this cycle.
- csr_we  out  1  single CSR-file write enable.
- csr_waddr  out  CSR  write address.
- csr_wdata  out  REG_WIDTH  write data.
- csr_raddr  out  CSR  combinational read address.
- csr_rdata  in  REG_WIDTH  combinational read data.
- stall  out  1  freeze the pipeline.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  REG_WIDTH  redirect target.
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 SHALL implement these FSM states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_REDIR, M_STATUS, M_REDIR.
REQ-005 SHALL, in IDLE with trap_req=1, latch trap_pc, trap_cause and trap_tval, then go to T_EPC; trap_req has priority over mret_req and instruction writes.
REQ-006 SHALL, in IDLE with mret_req=1 and trap_req=0, go to M_STATUS.
REQ-007 SHALL drive writes one per cycle through the single port:
- T_EPC: mepc <= latched pc with bits [1:0] cleared.
- T_CAUSE: mcause <= latched cause.
- T_TVAL: mtval <= latched tval.
REQ-008 SHALL, in T_STATUS, read mstatus and write it back with MPIE <= MIE (bit 7 <= bit 3), MIE <= 0, MPP[12:11] <= 2'b11; all other bits unchanged.
REQ-009 SHALL, in T_REDIR, read mtvec and assert redirect_valid=1 for exactly one cycle with redirect_pc = {mtvec[63:2], 2'b00} (direct mode only), then return to IDLE.
REQ-010 SHALL, in M_STATUS, read mstatus and write MIE <= MPIE, MPIE <= 1, MPP <= 2'b00; then go to M_REDIR.
REQ-011 SHALL, in M_REDIR, read mepc and pulse redirect_valid=1 with redirect_pc = mepc, then return to IDLE.
REQ-012 SHALL set inst_csr_ready = (state==IDLE) & ~trap_req & ~mret_req.
REQ-013 SHALL, when inst_csr_valid & inst_csr_ready, pass the instruction write through combinationally (csr_we=1, csr_waddr=inst_csr_addr, csr_wdata=inst_csr_wdata) with zero-cycle latency.
REQ-014 SHALL hold csr_we=0 in IDLE with no accepted instruction write, in T_REDIR and in M_REDIR.
REQ-015 SHALL drive stall = (state!=IDLE) | trap_req | mret_req.
REQ-016 SHALL ignore trap_req and mret_req outside IDLE; a simultaneous mret_req in the trap-accept cycle is dropped.
REQ-017 SHALL drive csr_raddr = 0 in every state that performs no read.
REQ-018 SHALL complete a trap in 6 cycles (accept through redirect) and an MRET in 3 cycles.

Reset
REQ-019 SHALL, on reset, set state=IDLE, clear the latched pc, cause and tval, and drive redirect_valid=0, csr_we=0 and stall=0 in the cycle following reset assertion.
REQ-020 SHALL, on reset mid-sequence, abort the sequence: no further CSR writes and no redirect are issued.

Structure
REQ-021 SHALL take the CSR addresses (mstatus 12'h300, mtvec 12'h305, mepc 12'h341, mcause 12'h342, mtval 12'h343), the mstatus bit positions and the FSM state enum from shared package csr_pkg.
REQ-022 SHALL be a single module with no sub-modules; it connects to the existing CSR register file via the write and read ports.

Verification
REQ-023 SHALL cover these directed scenarios:
- Trap: trap_pc=64'h8000_0104, cause=2, tval=64'hDEAD, mstatus=64'h8, mtvec=64'h8000_0001 -> writes mepc=8000_0104, mcause=2, mtval=DEAD, mstatus=64'h1880; redirect_pc=8000_0000 in cycle 5; stall high in cycles 0-5.
- MRET: mstatus=64'h1880, mepc=64'h8000_0200 -> mstatus=64'h88; redirect_pc=8000_0200 in cycle 2.
- Simultaneous trap_req, mret_req and inst_csr_valid in IDLE -> trap sequence runs, inst_csr_ready=0, no MRET effects.
- Instruction write addr=12'h340, data=64'h55 in IDLE -> same-cycle csr_we=1 with those values; a repeat write during a trap is held off until IDLE.
- Reset asserted in T_CAUSE -> no mtval or mstatus write, no redirect; state=IDLE.
